// File: rtl/lifo_channel_pointer.sv
// Stack pointer for one LIFO channel: counts stored entries 0..DEPTH.
// A simultaneous push and pop is a replace and leaves the pointer unchanged.
module lifo_channel_pointer #(
  parameter int DEPTH         = 4,
  parameter int POINTER_WIDTH = 3
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  output logic [POINTER_WIDTH-1:0] pointer,
  output logic                     full,
  output logic                     empty
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pointer <= '0;
    end else if (flush) begin
      pointer <= '0;
    end else if (push && !pop) begin
      pointer <= pointer + POINTER_WIDTH'(1);
    end else if (pop && !push) begin
      pointer <= pointer - POINTER_WIDTH'(1);
    end
  end

  assign full  = (pointer == POINTER_WIDTH'(DEPTH));
  assign empty = (pointer == '0);

endmodule

// File: rtl/lifo_multichannel_controller.sv
// CHANNELS independent LIFO stacks sharing one simple dual-port synchronous RAM.
// Channel c occupies RAM words c*DEPTH .. c*DEPTH+DEPTH-1; the RAM must be read-first.
module lifo_multichannel_controller #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int CHANNELS      = 2,
  parameter int DEPTH_LOG2    = $clog2(DEPTH),
  parameter int CHANNEL_LOG2  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int ADDRESS_WIDTH = $clog2(CHANNELS * DEPTH)
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  output logic [CHANNELS-1:0]                  full,
  output logic [CHANNELS-1:0]                  empty,
  output logic [CHANNELS*(DEPTH_LOG2+1)-1:0]   level,
  input  logic [CHANNELS-1:0]                  flush,
  input  logic                                 write_enable,
  input  logic [CHANNEL_LOG2-1:0]              write_channel,
  input  logic [WIDTH-1:0]                     write_data,
  input  logic                                 read_enable,
  input  logic [CHANNEL_LOG2-1:0]              read_channel,
  output logic                                 read_valid,
  output logic [WIDTH-1:0]                     read_data,
  output logic                                 overflow,
  output logic                                 underflow,
  output logic                                 memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0]             memory_write_address,
  output logic [WIDTH-1:0]                     memory_write_data,
  output logic                                 memory_read_enable,
  output logic [ADDRESS_WIDTH-1:0]             memory_read_address,
  input  logic [WIDTH-1:0]                     memory_read_data
);

  localparam int PW = DEPTH_LOG2 + 1;

  logic [PW-1:0]       pointer [CHANNELS];
  logic [CHANNELS-1:0] push_channel;
  logic [CHANNELS-1:0] pop_channel;

  logic          write_in_range, read_in_range;
  logic [PW-1:0] write_pointer, read_pointer;
  logic          write_full, write_flush;
  logic          read_empty, read_flush;
  logic          push_accept, pop_accept, replace;
  logic [PW-1:0] write_slot, read_slot;
  logic          overflow_next, underflow_next;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
    lifo_channel_pointer #(
      .DEPTH         (DEPTH),
      .POINTER_WIDTH (PW)
    ) u_pointer (
      .clock   (clock),
      .resetn  (resetn),
      .push    (push_channel[c]),
      .pop     (pop_channel[c]),
      .flush   (flush[c]),
      .pointer (pointer[c]),
      .full    (full[c]),
      .empty   (empty[c])
    );
    assign level[c*PW +: PW] = pointer[c];
    assign push_channel[c]   = push_accept && (write_channel == CHANNEL_LOG2'(c));
    assign pop_channel[c]    = pop_accept && (read_channel == CHANNEL_LOG2'(c));
  end

  assign write_in_range = (int'(write_channel) < CHANNELS);
  assign read_in_range  = (int'(read_channel) < CHANNELS);

  // Out-of-range channels fall through to the defaults and are rejected below.
  always_comb begin
    write_pointer = '0;
    write_full    = 1'b0;
    write_flush   = 1'b0;
    read_pointer  = '0;
    read_empty    = 1'b1;
    read_flush    = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (write_channel == CHANNEL_LOG2'(c)) begin
        write_pointer = pointer[c];
        write_full    = full[c];
        write_flush   = flush[c];
      end
      if (read_channel == CHANNEL_LOG2'(c)) begin
        read_pointer = pointer[c];
        read_empty   = empty[c];
        read_flush   = flush[c];
      end
    end
  end

  // A push that meets an accepted pop on the same channel overwrites the top entry.
  assign pop_accept  = read_enable && read_in_range && !read_flush && !read_empty;
  assign replace     = pop_accept && (write_channel == read_channel);
  assign push_accept = write_enable && write_in_range && !write_flush && (!write_full || replace);

  assign write_slot = replace ? (write_pointer - PW'(1)) : write_pointer;
  assign read_slot  = read_pointer - PW'(1);

  assign memory_write_enable  = push_accept;
  assign memory_write_address = ADDRESS_WIDTH'(int'(write_channel) * DEPTH + int'(write_slot));
  assign memory_write_data    = write_data;
  assign memory_read_enable   = pop_accept;
  assign memory_read_address  = ADDRESS_WIDTH'(int'(read_channel) * DEPTH + int'(read_slot));

  // Ops cancelled by a flush are neither performed nor reported as errors.
  assign overflow_next  = write_enable && !(write_in_range && write_flush) && !push_accept;
  assign underflow_next = read_enable && !(read_in_range && read_flush) && !pop_accept;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      read_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      read_valid <= pop_accept;
      overflow   <= overflow_next;
      underflow  <= underflow_next;
    end
  end

  assign read_data = memory_read_data;

endmodule

// File: tb/tb_lifo_multichannel_controller.sv
// Bench for lifo_multichannel_controller: read-first RAM model plus per-channel stack model.
module tb_lifo_multichannel_controller;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int CHANNELS = 3;

  logic       clock = 1'b0;
  logic       resetn;
  logic [2:0] full, empty;
  logic [8:0] level;
  logic [2:0] flush;
  logic       write_enable;
  logic [1:0] write_channel;
  logic [7:0] write_data;
  logic       read_enable;
  logic [1:0] read_channel;
  logic       read_valid;
  logic [7:0] read_data;
  logic       overflow, underflow;
  logic       memory_write_enable;
  logic [3:0] memory_write_address;
  logic [7:0] memory_write_data;
  logic       memory_read_enable;
  logic [3:0] memory_read_address;
  logic [7:0] memory_read_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [CHANNELS*DEPTH];
  logic [7:0] stack_data [CHANNELS][DEPTH];
  int         stack_size [CHANNELS];

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (memory_read_enable) memory_read_data <= ram[memory_read_address];
    if (memory_write_enable) ram[memory_write_address] <= memory_write_data;
  end

  lifo_multichannel_controller #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clock                (clock),
    .resetn               (resetn),
    .full                 (full),
    .empty                (empty),
    .level                (level),
    .flush                (flush),
    .write_enable         (write_enable),
    .write_channel        (write_channel),
    .write_data           (write_data),
    .read_enable          (read_enable),
    .read_channel         (read_channel),
    .read_valid           (read_valid),
    .read_data            (read_data),
    .overflow             (overflow),
    .underflow            (underflow),
    .memory_write_enable  (memory_write_enable),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .memory_read_enable   (memory_read_enable),
    .memory_read_address  (memory_read_address),
    .memory_read_data     (memory_read_data)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_status(input string tag);
    logic [8:0] exp_level;
    logic [2:0] exp_full, exp_empty;
    for (int c = 0; c < CHANNELS; c++) begin
      exp_level[c*3 +: 3] = 3'(stack_size[c]);
      exp_full[c]         = (stack_size[c] == DEPTH);
      exp_empty[c]        = (stack_size[c] == 0);
    end
    check({tag, " level"}, 32'(level), 32'(exp_level));
    check({tag, " full"}, 32'(full), 32'(exp_full));
    check({tag, " empty"}, 32'(empty), 32'(exp_empty));
  endtask

  // One clock cycle of stimulus; predictions come from the stack model only.
  task automatic step(input logic we, input logic [1:0] wch, input logic [7:0] wd,
                      input logic re, input logic [1:0] rch, input logic [2:0] fl);
    bit         w_ok, r_ok, w_fl, r_fl, pop_ok, push_ok, same;
    bit         exp_ovf, exp_unf;
    logic [7:0] exp_rd;
    int         w_addr, r_addr;
    @(negedge clock);
    write_enable  = we;
    write_channel = wch;
    write_data    = wd;
    read_enable   = re;
    read_channel  = rch;
    flush         = fl;
    w_ok    = we && (wch < CHANNELS);
    r_ok    = re && (rch < CHANNELS);
    w_fl    = w_ok && fl[wch];
    r_fl    = r_ok && fl[rch];
    same    = (wch == rch);
    pop_ok  = r_ok && !r_fl && (stack_size[rch] > 0);
    push_ok = w_ok && !w_fl && ((stack_size[wch] < DEPTH) || (pop_ok && same));
    exp_ovf = we && !w_fl && !push_ok;
    exp_unf = re && !r_fl && !pop_ok;
    w_addr  = 0;
    r_addr  = 0;
    exp_rd  = '0;
    if (push_ok) w_addr = wch * DEPTH + ((pop_ok && same) ? stack_size[wch] - 1 : stack_size[wch]);
    if (pop_ok) begin
      r_addr = rch * DEPTH + stack_size[rch] - 1;
      exp_rd = stack_data[rch][stack_size[rch] - 1];
    end
    #1;
    check("mem_write_enable", 32'(memory_write_enable), 32'(push_ok));
    if (push_ok) begin
      check("mem_write_address", 32'(memory_write_address), 32'(w_addr));
      check("mem_write_data", 32'(memory_write_data), 32'(wd));
    end
    check("mem_read_enable", 32'(memory_read_enable), 32'(pop_ok));
    if (pop_ok) check("mem_read_address", 32'(memory_read_address), 32'(r_addr));
    if (pop_ok) stack_size[rch]--;
    if (push_ok) begin
      stack_data[wch][stack_size[wch]] = wd;
      stack_size[wch]++;
    end
    for (int c = 0; c < CHANNELS; c++) if (fl[c]) stack_size[c] = 0;
    @(posedge clock);
    #1;
    check("read_valid", 32'(read_valid), 32'(pop_ok));
    if (pop_ok) check("read_data", 32'(read_data), 32'(exp_rd));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
    check_status("step");
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    step(1'b1, ch, d, 1'b0, 2'd0, 3'b000);
  endtask

  task automatic pop(input logic [1:0] ch);
    step(1'b0, 2'd0, 8'h00, 1'b1, ch, 3'b000);
  endtask

  initial begin
    resetn        = 1'b0;
    flush         = '0;
    write_enable  = 1'b0;
    write_channel = '0;
    write_data    = '0;
    read_enable   = 1'b0;
    read_channel  = '0;
    for (int c = 0; c < CHANNELS; c++) stack_size[c] = 0;
    repeat (2) @(posedge clock);
    #1;
    check("reset read_valid", 32'(read_valid), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset underflow", 32'(underflow), 32'd0);
    check("reset mem strobes", 32'({memory_write_enable, memory_read_enable}), 32'd0);
    check_status("reset");
    @(negedge clock);
    resetn = 1'b1;

    // fill ch1 then overflow
    push(2'd1, 8'h11); push(2'd1, 8'h22); push(2'd1, 8'h33); push(2'd1, 8'h44);
    push(2'd1, 8'h55);
    // drain ch1 then underflow
    repeat (5) pop(2'd1);
    // replace on full ch1, then pop the replacement
    push(2'd1, 8'h11); push(2'd1, 8'h22); push(2'd1, 8'h33); push(2'd1, 8'h44);
    step(1'b1, 2'd1, 8'hAA, 1'b1, 2'd1, 3'b000);
    pop(2'd1);
    // independent push ch0 and pop ch2
    push(2'd2, 8'h5A); push(2'd2, 8'h7E);
    step(1'b1, 2'd0, 8'h01, 1'b1, 2'd2, 3'b000);
    // flush overrides ops on ch0; channel 3 is rejected
    push(2'd0, 8'h02);
    step(1'b1, 2'd0, 8'h03, 1'b1, 2'd0, 3'b001);
    step(1'b1, 2'd3, 8'h04, 1'b1, 2'd3, 3'b000);
    // empty-channel push+pop: push accepted, pop underflows
    step(1'b1, 2'd0, 8'h05, 1'b1, 2'd0, 3'b000);
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 3'b000);

    for (int i = 0; i < 400; i++) begin
      logic [1:0] wch, rch;
      logic [2:0] fl;
      wch = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rch = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      fl  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      step(1'($urandom_range(0, 1)), wch, 8'($urandom), 1'($urandom_range(0, 1)), rch, fl);
    end

    // reset while a pop result is being presented
    push(2'd0, 8'hC3);
    @(negedge clock);
    write_enable = 1'b0;
    flush        = '0;
    read_enable  = 1'b1;
    read_channel = 2'd0;
    @(posedge clock);
    #1;
    check("pre-reset read_valid", 32'(read_valid), 32'd1);
    read_enable = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    for (int c = 0; c < CHANNELS; c++) stack_size[c] = 0;
    check("mid-reset read_valid", 32'(read_valid), 32'd0);
    check_status("mid-reset");
    @(negedge clock);
    resetn = 1'b1;
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
